// File: rtl/sv_lcd_scanout.sv
// sv_lcd_scanout: Supervision LCD-to-VGA scanout. Generates VGA timing,
// maps the LCD window (scale, border, scroll, clip) onto it and prefetches
// each LCD row from VRAM during hblank into a double-buffered line buffer.
module sv_lcd_scanout #(
    parameter int H_TOTAL      = 800,
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 672,
    parameter int H_SYNC_END   = 720,
    parameter int V_TOTAL      = 525,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 481,
    parameter int V_SYNC_END   = 484,
    parameter int SCALE        = 2,
    parameter int LCD_W        = 160,
    parameter int LCD_H        = 160,
    parameter int BORDER_X     = 80,
    parameter int BORDER_Y     = 40,
    parameter int ROW_BYTES    = 48,
    parameter int VRAM_ROWS    = 170
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        white,
    input  logic [7:0]  lcd_xsize,
    input  logic [7:0]  lcd_ysize,
    input  logic [7:0]  lcd_xscroll,
    input  logic [7:0]  lcd_yscroll,
    output logic [12:0] addr,
    output logic        rd,
    input  logic [7:0]  data,
    output logic        ce_pxl,
    output logic        hsync,
    output logic        vsync,
    output logic        hblank,
    output logic        vblank,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue
);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int NB = LCD_W / 4 + 1;   // one spare byte covers fine scroll
    localparam int BW = $clog2(NB);

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN} fetch_state_t;

    // 2-bit LCD shade to 24-bit RGB for the selected palette
    function automatic logic [23:0] palette(input logic grey, input logic [1:0] c);
        logic [23:0] rgb;
        if (grey) begin
            case (c)
                2'd0:    rgb = 24'hFFFFFF;
                2'd1:    rgb = 24'hC0C0C0;
                2'd2:    rgb = 24'h808080;
                default: rgb = 24'h000000;
            endcase
        end else begin
            case (c)
                2'd0:    rgb = 24'h87BA6B;
                2'd1:    rgb = 24'h6BA378;
                2'd2:    rgb = 24'h386B82;
                default: rgb = 24'h384052;
            endcase
        end
        return rgb;
    endfunction

    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic          h_last_s;

    fetch_state_t  state_q;
    logic [BW-1:0] idx_q, wr_idx_q;
    logic [12:0]   addr_q;
    logic          rd_q, sel_q, wr_v_q;
    logic [7:0]    lbuf_q [0:1][0:NB-1];

    logic          ce_pxl_q, hsync_q, vsync_q, hblank_q, vblank_q;
    logic [23:0]   rgb_q;

    logic [HW-1:0] vx_s, lx_s;
    logic [VW-1:0] vy_s, ly_s;
    logic [15:0]   p_s;
    logic [8:0]    xs_eff_s, ys_eff_s;
    logic          in_win_s, clip_s;
    logic [BW-1:0] bidx_s;
    logic [7:0]    byte_s;
    logic [1:0]    pix_s;
    logic [23:0]   rgb_s;

    logic [VW-1:0] nv_s, nvy_s, row_s;
    logic          disp_next_s;
    logic [15:0]   row_sum_s, row_mod_s;
    logic [12:0]   base_s;

    // Raster counter next state: hcount wraps each line, vcount each frame
    always_comb begin
        h_last_s = (hcount_q == HW'(H_TOTAL - 1));
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (h_last_s) begin
            hcount_d = '0;
            if (vcount_q == VW'(V_TOTAL - 1)) begin
                vcount_d = '0;
            end else begin
                vcount_d = vcount_q + VW'(1);
            end
        end else begin
            hcount_d = hcount_q + HW'(1);
        end
    end

    // Raster counters, advancing only on ce
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else if (ce) begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    // Window mapping, clipping and pixel lookup from the display bank
    always_comb begin
        vx_s     = hcount_q / HW'(SCALE);
        vy_s     = vcount_q / VW'(SCALE);
        in_win_s = (hcount_q < HW'(H_ACTIVE)) && (vcount_q < VW'(V_ACTIVE))
                && (vx_s >= HW'(BORDER_X)) && (vx_s < HW'(BORDER_X + LCD_W))
                && (vy_s >= VW'(BORDER_Y)) && (vy_s < VW'(BORDER_Y + LCD_H));
        lx_s     = vx_s - HW'(BORDER_X);
        ly_s     = vy_s - VW'(BORDER_Y);
        xs_eff_s = (lcd_xsize == 8'd0) ? 9'(LCD_W) : {1'b0, lcd_xsize};
        ys_eff_s = (lcd_ysize == 8'd0) ? 9'(LCD_H) : {1'b0, lcd_ysize};
        clip_s   = (16'(lx_s) >= 16'(xs_eff_s)) || (16'(ly_s) >= 16'(ys_eff_s));
        p_s      = 16'(lx_s) + 16'(lcd_xscroll[1:0]);
        bidx_s   = in_win_s ? BW'(p_s >> 2) : '0;
        byte_s   = lbuf_q[sel_q][bidx_s];
        pix_s    = 2'(byte_s >> {p_s[1:0], 1'b0});
        rgb_s    = (in_win_s && !clip_s) ? palette(white, pix_s) : 24'h000000;
    end

    // Next-line lookahead: which LCD row the following line shows, and its VRAM base
    always_comb begin
        nv_s        = (vcount_q == VW'(V_TOTAL - 1)) ? '0 : vcount_q + VW'(1);
        nvy_s       = nv_s / VW'(SCALE);
        disp_next_s = (nv_s < VW'(V_ACTIVE)) && (nvy_s >= VW'(BORDER_Y))
                   && (nvy_s < VW'(BORDER_Y + LCD_H));
        row_s       = nvy_s - VW'(BORDER_Y);
        row_sum_s   = 16'(lcd_yscroll) + 16'(row_s);
        row_mod_s   = row_sum_s % 16'(VRAM_ROWS);
        base_s      = 13'(row_mod_s * 16'(ROW_BYTES) + 16'(lcd_xscroll[7:2]));
    end

    // Prefetch sequencer: one VRAM read per ce in hblank, bank swap at line end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            addr_q   <= 13'd0;
            rd_q     <= 1'b0;
            sel_q    <= 1'b0;
            wr_v_q   <= 1'b0;
            wr_idx_q <= '0;
        end else if (ce) begin
            // a read issued this cycle returns data next ce cycle
            wr_v_q   <= rd_q;
            wr_idx_q <= idx_q;
            if (h_last_s) begin
                sel_q <= ~sel_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if ((hcount_q == HW'(H_ACTIVE)) && disp_next_s) begin
                        state_q <= ST_FETCH;
                        rd_q    <= 1'b1;
                        addr_q  <= base_s;
                        idx_q   <= '0;
                    end
                end
                ST_FETCH: begin
                    if (idx_q == BW'(NB - 1)) begin
                        rd_q    <= 1'b0;
                        state_q <= ST_DRAIN;
                    end else begin
                        idx_q  <= idx_q + BW'(1);
                        addr_q <= addr_q + 13'd1;
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    rd_q    <= 1'b0;
                end
            endcase
        end
    end

    // Line buffer write into the fetch bank; contents are not cleared by reset
    always_ff @(posedge clk) begin
        if (ce && wr_v_q) begin
            lbuf_q[~sel_q][wr_idx_q] <= data;
        end
    end

    // Registered video outputs, one ce-cycle behind the raster counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ce_pxl_q <= 1'b0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
            rgb_q    <= 24'h000000;
        end else if (ce) begin
            ce_pxl_q <= ((hcount_q % HW'(SCALE)) == HW'(SCALE - 1));
            hsync_q  <= !((hcount_q >= HW'(H_SYNC_START)) && (hcount_q < HW'(H_SYNC_END)));
            vsync_q  <= !((vcount_q >= VW'(V_SYNC_START)) && (vcount_q < VW'(V_SYNC_END)));
            hblank_q <= (hcount_q >= HW'(H_ACTIVE));
            vblank_q <= (vcount_q >= VW'(V_ACTIVE));
            rgb_q    <= rgb_s;
        end
    end

    assign addr   = addr_q;
    assign rd     = rd_q;
    assign ce_pxl = ce_pxl_q;
    assign hsync  = hsync_q;
    assign vsync  = vsync_q;
    assign hblank = hblank_q;
    assign vblank = vblank_q;
    assign red    = rgb_q[23:16];
    assign green  = rgb_q[15:8];
    assign blue   = rgb_q[7:0];
endmodule

// File: tb/tb_sv_lcd_scanout.sv
// Testbench for sv_lcd_scanout: reduced timing so several frames fit in the
// run; random ce, palette toggles and scroll/size settings per frame, checked
// through a scoreboard against a frame-level reference model.
module tb_sv_lcd_scanout;
    localparam int HT = 100, HA = 80, HSS = 84, HSE = 90;
    localparam int VT = 60, VA = 50, VSS = 52, VSE = 54;
    localparam int S = 2, LW = 32, LH = 20, BX = 4, BY = 2;
    localparam int RB = 300, VR = 30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic        white = 1'b0;
    logic [7:0]  xsize = 8'd0, ysize = 8'd0, xscroll = 8'd0, yscroll = 8'd0;
    logic [12:0] addr;
    logic        rd;
    logic [7:0]  data = 8'd0;
    logic        ce_pxl, hsync, vsync, hblank, vblank;
    logic [7:0]  red, green, blue;

    sv_lcd_scanout #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE),
        .SCALE(S), .LCD_W(LW), .LCD_H(LH), .BORDER_X(BX), .BORDER_Y(BY),
        .ROW_BYTES(RB), .VRAM_ROWS(VR)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .white(white),
        .lcd_xsize(xsize), .lcd_ysize(ysize), .lcd_xscroll(xscroll), .lcd_yscroll(yscroll),
        .addr(addr), .rd(rd), .data(data), .ce_pxl(ce_pxl),
        .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
        .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    logic [7:0] vram [0:8191];

    // VRAM: data valid the ce-cycle after a read strobe
    always @(posedge clk) if (ce && rd) data <= vram[addr];

    typedef struct packed {
        logic        cp, hs, vs, hb, vb;
        logic [23:0] rgb;
        logic        rdv;
        logic [12:0] ad;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0, failures = 0;
    int          mh = 0, mv = 0, fr = 0, cyc = 0;
    logic [12:0] last_addr = 13'd0;
    bit          rel_pending = 1'b0, did_mid = 1'b0, did_freeze = 1'b0;

    function automatic exp_t rst_exp();
        exp_t e;
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        return e;
    endfunction

    function automatic logic [23:0] pal(input logic w, input int c);
        if (w) return (c == 0) ? 24'hFFFFFF : (c == 1) ? 24'hC0C0C0 : (c == 2) ? 24'h808080 : 24'h000000;
        return (c == 0) ? 24'h87BA6B : (c == 1) ? 24'h6BA378 : (c == 2) ? 24'h386B82 : 24'h384052;
    endfunction

    // Reference: expected registered outputs for raster position (mh,mv)
    task automatic expect_cycle();
        exp_t e;
        int vx, vy, lx, ly, xe, ye, p, a, nv, nvy, c;
        bit inw, disp;
        e.cp  = ((mh % S) == S - 1);
        e.hs  = !(mh >= HSS && mh < HSE);
        e.vs  = !(mv >= VSS && mv < VSE);
        e.hb  = (mh >= HA);
        e.vb  = (mv >= VA);
        vx = mh / S; vy = mv / S;
        inw = (mh < HA) && (mv < VA) && (vx >= BX) && (vx < BX + LW) && (vy >= BY) && (vy < BY + LH);
        lx = vx - BX; ly = vy - BY;
        xe = (xsize == 8'd0) ? LW : int'(xsize);
        ye = (ysize == 8'd0) ? LH : int'(ysize);
        e.rgb = 24'h000000;
        if (inw && lx < xe && ly < ye) begin
            p = lx + int'(xscroll[1:0]);
            a = (((int'(yscroll) + ly) % VR) * RB + int'(xscroll[7:2]) + p / 4) % 8192;
            c = (int'(vram[a]) >> (2 * (p % 4))) & 3;
            e.rgb = pal(white, c);
        end
        nv   = (mv == VT - 1) ? 0 : mv + 1;
        nvy  = nv / S;
        disp = (nv < VA) && (nvy >= BY) && (nvy < BY + LH);
        if (disp && mh >= HA && mh <= HA + LW / 4) begin
            e.rdv = 1'b1;
            last_addr = 13'((((int'(yscroll) + nvy - BY) % VR) * RB + int'(xscroll[7:2]) + (mh - HA)) % 8192);
        end else begin
            e.rdv = 1'b0;
        end
        e.ad = last_addr;
        expq.push_back(e);
    endtask

    task automatic compare(input exp_t e);
        logic [4:0] gsb;
        gsb = {ce_pxl, hsync, vsync, hblank, vblank};
        checks++;
        if (gsb !== {e.cp, e.hs, e.vs, e.hb, e.vb}) begin
            failures++;
            $display("FAIL sync_blank t=%0t got=%b exp=%b", $time, gsb, {e.cp, e.hs, e.vs, e.hb, e.vb});
        end
        checks++;
        if ({red, green, blue} !== e.rgb) begin
            failures++;
            $display("FAIL rgb t=%0t got=%06h exp=%06h", $time, {red, green, blue}, e.rgb);
        end
        checks++;
        if ({rd, addr} !== {e.rdv, e.ad}) begin
            failures++;
            $display("FAIL rd_addr t=%0t got rd=%b addr=%0d exp rd=%b addr=%0d", $time, rd, addr, e.rdv, e.ad);
        end
    endtask

    task automatic check_reset(input string name);
        checks++;
        if ({ce_pxl, hsync, vsync, hblank, vblank, red, green, blue, rd, addr} !== rst_exp()) begin
            failures++;
            $display("FAIL %s got sync=%b rgb=%06h rd=%b addr=%0d exp sync=01100 rgb=000000 rd=0 addr=0",
                     name, {ce_pxl, hsync, vsync, hblank, vblank}, {red, green, blue}, rd, addr);
        end
    endtask

    task automatic set_phase(input int f);
        case (f)
            1: begin yscroll = 8'(VR - 1); xscroll = 8'd6; xsize = 8'd0; ysize = 8'd0; end
            2: begin xsize = 8'd20; ysize = 8'd10; xscroll = 8'($urandom); yscroll = 8'($urandom); end
            default: begin
                xsize = 8'($urandom_range(0, 40)); ysize = 8'($urandom_range(0, 25));
                xscroll = 8'($urandom); yscroll = 8'($urandom);
            end
        endcase
    endtask

    // One negedge of stimulus: pick ce, maybe flip palette, push expectation
    task automatic step(input bit ce_low);
        @(negedge clk);
        if (rel_pending) begin
            reset = 1'b0;
            rel_pending = 1'b0;
        end
        ce = ce_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 149) == 0) white = ~white;
        if (ce) begin
            if (mh == 0 && mv == 47) begin
                fr++;
                set_phase(fr);
            end
            expect_cycle();
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end
    endtask

    // Reset in the middle of a prefetch: rd must drop at once
    task automatic do_reset();
        @(negedge clk);
        checks++;
        if (rd !== 1'b1) begin
            failures++;
            $display("FAIL rd_prefetch got=%b exp=1", rd);
        end
        ce = 1'b0;
        reset = 1'b1;
        #1;
        check_reset("reset_mid");
        expq.delete();
        mh = 0; mv = 0; last_addr = 13'd0;
        repeat (2) @(negedge clk);
        rel_pending = 1'b1;
    endtask

    // Monitor: pop on every ce edge, otherwise outputs must hold
    initial begin
        exp_t e, last;
        last = rst_exp();
        forever begin
            @(posedge clk);
            if (reset) begin
                last = rst_exp();
            end else if (ce) begin
                #1;
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard_empty t=%0t got=0 entries exp>=1", $time);
                end else begin
                    e = expq.pop_front();
                    compare(e);
                    last = e;
                end
            end else begin
                #1;
                compare(last);
            end
        end
    end

    initial begin
        for (int i = 0; i < 8192; i++) vram[i] = 8'($urandom);
        vram[0] = 8'h1B;
        repeat (3) @(negedge clk);
        check_reset("reset_init");
        rel_pending = 1'b1;
        while (fr < 5 && cyc < 90000) begin
            if (!did_mid && fr == 2 && mv == 20 && mh == 83) begin
                did_mid = 1'b1;
                do_reset();
            end else if (!did_freeze && fr == 1 && mv == 10 && mh == 30) begin
                did_freeze = 1'b1;
                repeat (10) step(1'b1);
            end else begin
                step(1'b0);
            end
            cyc++;
        end
        checks++;
        if (cyc >= 90000) begin
            failures++;
            $display("FAIL run_budget got cycles=%0d exp<90000", cyc);
        end
        @(negedge clk);
        ce = 1'b0;
        @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sv_lcd_scanout.md
Name: sv_lcd_scanout

Overview:
- Second-generation Supervision LCD-to-VGA scanout, replacing the fixed 160x160 converter.
- Generalised timing, scale and border; applies lcd_xscroll/lcd_yscroll, including 2-bit fine X scroll, and lcd_xsize/lcd_ysize clipping.
- Prefetches each LCD row from VRAM during hblank into a double-buffered line buffer, so VRAM reads leave the active region entirely.
- Sits between the LCD control registers / VRAM port and the MiSTer video output.

Parameters:
- H_TOTAL, 800, clocks per VGA line
- H_ACTIVE, 640, visible clocks per line
- H_SYNC_START, 672, first hsync clock
- H_SYNC_END, 720, first clock after hsync
- V_TOTAL, 525, lines per frame
- V_ACTIVE, 480, visible lines
- V_SYNC_START, 481, first vsync line
- V_SYNC_END, 484, first line after vsync
- SCALE, 2, VGA clocks/lines per LCD pixel (1..4)
- LCD_W, 160, LCD pixels per row (multiple of 4)
- LCD_H, 160, LCD rows
- BORDER_X, 80, left border in LCD pixels
- BORDER_Y, 40, top border in LCD rows
- ROW_BYTES, 48, VRAM bytes per row
- VRAM_ROWS, 170, rows in VRAM for Y wrap

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- ce  in  1  clock enable; when low, all state holds
- white  in  1  1 = grey palette, 0 = green palette
- lcd_xsize  in  8  visible width; 0 means LCD_W
- lcd_ysize  in  8  visible height; 0 means LCD_H
- lcd_xscroll  in  8  X scroll in pixels
- lcd_yscroll  in  8  Y scroll in rows
- addr  out  13  VRAM byte address
- rd  out  1  VRAM read strobe
- data  in  8  VRAM data, valid the ce-cycle after rd
- ce_pxl  out  1  high once per SCALE clocks
- hsync, vsync  out  1  active-low
- hblank, vblank  out  1  active-high
- red, green, blue  out  8 each  pixel colour

Behaviour:
- Reset value of every output is 0, except hsync and vsync, which are 1. On reset: hcount=vcount=0, FSM=IDLE, buffer select=0. Line buffer contents are not cleared.
- Counters advance only when ce=1.
  - hcount wraps at H_TOTAL-1.
  - vcount increments when hcount=H_TOTAL-1 and wraps at V_TOTAL-1 on that same clock.
- Outputs are registered with 1-cycle latency: the value for counter state (h,v) appears on the next ce cycle. Syncs and blanks use the same delay, so they stay aligned with RGB.
- ce_pxl = (hcount mod SCALE)==SCALE-1.
- Coordinates:
  - vx = hcount/SCALE, vy = vcount/SCALE.
  - The window is BORDER_X <= vx < BORDER_X+LCD_W and BORDER_Y <= vy < BORDER_Y+LCD_H, inside the active region.
  - lx = vx-BORDER_X, ly = vy-BORDER_Y.
- Clipping: pixels with lx >= effective xsize or ly >= effective ysize output black.
- Line buffer: 2 banks x (LCD_W/4+1) bytes. The display reads bank sel; the fetch writes bank ~sel. sel toggles when hcount=H_TOTAL-1.
- Fetch FSM: IDLE -> FETCH -> DRAIN -> IDLE.
  - Trigger: hcount==H_ACTIVE when the next line is displayable. The next line (vcount+1, or 0 on wrap) maps to LCD row r in 0..LCD_H-1.
  - FETCH: issues rd=1 for i=0..LCD_W/4, one per ce cycle. addr = (((lcd_yscroll+r) mod VRAM_ROWS)*ROW_BYTES + lcd_xscroll[7:2] + i) mod 8192.
  - Each returned byte is written to byte i of bank ~sel one cycle later.
  - DRAIN: captures the final byte, then returns to IDLE.
  - Total: LCD_W/4+2 cycles, which must be < H_TOTAL-H_ACTIVE.
  - Scroll registers are sampled once at the trigger and held for the whole fetch.
- Fetch on non-displayable lines: no fetch, rd=0, and addr holds its last value.
- Fetch on every displayable line, even when r repeats because SCALE>1.
- Pixel select: p = lx + lcd_xscroll[1:0]. Use byte p>>2 and bits [2*(p&3)+1 : 2*(p&3)]; the low pair is the leftmost pixel.
- Palette:
  - green (white=0): 00 87BA6B, 01 6BA378, 10 386B82, 11 384052
  - grey (white=1): 00 FFFFFF, 01 C0C0C0, 10 808080, 11 000000
- Outside the window or in blanking, RGB = 000000.
- Reset mid-fetch aborts the fetch. rd falls immediately (asynchronously), and the partial bank is discarded by the next full fetch.
- SCALE=1 with default timing is legal; the window shrinks accordingly.

Test Plan:
- Reset asserted mid-line -> hsync=vsync=1, all else 0. After release, hsync low for hcount 672..719 (seen 1 cycle later), vsync low on lines 481..483, frame period 420000 clocks.
- VRAM[0]=0x1B, no scroll, white=0 -> LCD(0,0..3) at vcount 80..81, hcount 160..167 shows colours 11,10,01,00 = 384052, 386B82, 6BA378, 87BA6B.
- Fetch for LCD row 0: at vcount=79, hcount=640 -> rd high 41 cycles, addr 0..40. No rd during active video.
- lcd_yscroll=169, lcd_xscroll=6 -> row 1 fetch starts at addr 0+1=0x001 (wrapped row 0). LCD pixel 0 is bits[5:4] of the first byte.
- lcd_xsize=100, lcd_ysize=50 -> lx>=100 or ly>=50 output 000000, while hblank/vblank stay unchanged.
- white toggled mid-frame -> the next pixel switches palette (00 becomes FFFFFF). ce=0 for 10 cycles -> counters and outputs freeze.
